xaui_link_ctrl: RTL and testbench



---
 rtl/xaui_ctrl_pkg.sv | 34 +++
 rtl/xaui_ctrl_timer.sv | 40 ++++
 rtl/xaui_link_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_xaui_link_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xaui_ctrl_pkg.sv
// Shared definitions for the XAUI link bring-up controller: state encodings,
// configuration/status vector bit positions and small helpers.
package xaui_ctrl_pkg;

  localparam int TMR_W = 16;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_RST        = 3'd1;
  localparam logic [2:0] ST_WAIT_LOCK  = 3'd2;
  localparam logic [2:0] ST_WAIT_SYNC  = 3'd3;
  localparam logic [2:0] ST_WAIT_ALIGN = 3'd4;
  localparam logic [2:0] ST_CLR_FAULT  = 3'd5;
  localparam logic [2:0] ST_UP         = 3'd6;
  localparam logic [2:0] ST_FAILED     = 3'd7;

  // configuration_vector bit positions
  localparam int CV_LOOPBACK   = 0;
  localparam int CV_POWERDOWN  = 1;
  localparam int CV_RST_LFAULT = 2;
  localparam int CV_RST_RXLINK = 3;

  // status_vector bit positions
  localparam int SV_TX_LFAULT = 0;
  localparam int SV_RX_LFAULT = 1;
  localparam int SV_RX_LINK   = 7;

  // Number of cycles the fault/link-status clear bits are held in CLR_FAULT.
  localparam int CLR_PULSE_CYCLES = 2;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/xaui_ctrl_timer.sv
// Shared state timer: counts up from zero after clr and flags done on the
// cycle the count reaches limit-1. A zero limit disables done. The count
// saturates so it never wraps while parked in a state with no timeout.
module xaui_ctrl_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         done,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // next count: clear on request, otherwise saturating increment
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (count_q != '1) begin
      count_d = count_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign done  = (limit != '0) && (count_q == (limit - 1'b1));

endmodule

// File: rtl/xaui_link_ctrl.sv
// XAUI link bring-up controller: sequences core reset, transceiver lock,
// lane sync, lane alignment and fault clearing, with bounded retries and a
// count of link drops.
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | link not requested, core held in reset
// RST        | core held in reset for RST_CYCLES
// WAIT_LOCK  | waiting for all four transceiver PLLs to lock
// WAIT_SYNC  | waiting for sync and signal detect on all lanes
// WAIT_ALIGN | waiting for lane alignment
// CLR_FAULT  | pulse fault/link-status clears, then wait for clean status
// UP         | link operational, watching for loss
// FAILED     | retries exhausted, waiting for restart or enable low
module xaui_link_ctrl
  import xaui_ctrl_pkg::*;
#(
  parameter int RST_CYCLES    = 32,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int ALIGN_TIMEOUT = 20000,
  parameter int MAX_RETRY     = 7
) (
  input  logic        usrclk,
  input  logic        reset,
  input  logic        enable,
  input  logic        restart,
  input  logic        cfg_loopback,
  input  logic        cfg_powerdown,
  input  logic [3:0]  mgt_rxlock,
  input  logic [3:0]  signal_detect,
  input  logic [3:0]  sync_status,
  input  logic        align_status,
  input  logic [7:0]  status_vector,
  output logic        core_reset,
  output logic [6:0]  configuration_vector,
  output logic        link_up,
  output logic        link_failed,
  output logic [2:0]  state,
  output logic [2:0]  retry_cnt,
  output logic [15:0] link_drop_cnt
);

  logic [2:0]       state_q, state_d;
  logic [2:0]       retry_cnt_q, retry_cnt_d;
  logic [15:0]      link_drop_cnt_q, link_drop_cnt_d;
  logic [1:0]       cfg_q, cfg_d;

  logic             tmr_clr;
  logic             tmr_done;
  logic [TMR_W-1:0] tmr_limit;
  logic [TMR_W-1:0] tmr_count;

  logic             timeout;
  logic [3:0]       retry_inc;
  logic             status_ok;
  logic             link_lost;
  logic             clr_pulse;
  logic             clr_pulse_done;
  logic             sv_unused;

  // status bits 6:2 carry nothing this controller acts on
  assign sv_unused = ^status_vector[6:2];

  assign status_ok = status_vector[SV_RX_LINK] && !status_vector[SV_RX_LFAULT]
                     && !status_vector[SV_TX_LFAULT];
  assign link_lost = !align_status || !(&sync_status) || status_vector[SV_RX_LFAULT];

  // One extra bit so the retry compare cannot wrap; retry_cnt itself is
  // 3 bits, so MAX_RETRY is meaningful up to 7.
  assign retry_inc = {1'b0, retry_cnt_q} + 4'd1;

  assign clr_pulse      = (state_q == ST_CLR_FAULT) && (tmr_count < TMR_W'(CLR_PULSE_CYCLES));
  assign clr_pulse_done = tmr_count >= TMR_W'(CLR_PULSE_CYCLES - 1);

  // per-state timeout limit; CLR_FAULT shares the alignment budget
  always_comb begin
    tmr_limit = '0;
    case (state_q)
      ST_RST:                      tmr_limit = TMR_W'(RST_CYCLES);
      ST_WAIT_LOCK, ST_WAIT_SYNC:  tmr_limit = TMR_W'(LOCK_TIMEOUT);
      ST_WAIT_ALIGN, ST_CLR_FAULT: tmr_limit = TMR_W'(ALIGN_TIMEOUT);
      default:                     tmr_limit = '0;
    endcase
  end

  // next-state logic: enable low beats restart, restart beats everything
  // else, and a success condition beats a coinciding timeout
  always_comb begin
    state_d         = state_q;
    retry_cnt_d     = retry_cnt_q;
    link_drop_cnt_d = link_drop_cnt_q;
    tmr_clr         = 1'b0;
    timeout         = 1'b0;
    if (!enable) begin
      state_d     = ST_IDLE;
      retry_cnt_d = '0;
      tmr_clr     = (state_q != ST_IDLE);
    end else if (restart && (state_q != ST_IDLE)) begin
      state_d     = ST_RST;
      retry_cnt_d = '0;
      tmr_clr     = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_RST;
          tmr_clr = 1'b1;
        end
        ST_RST: begin
          if (tmr_done) begin
            state_d = ST_WAIT_LOCK;
            tmr_clr = 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (&mgt_rxlock) begin
            state_d = ST_WAIT_SYNC;
            tmr_clr = 1'b1;
          end else begin
            timeout = tmr_done;
          end
        end
        ST_WAIT_SYNC: begin
          if ((&sync_status) && (&signal_detect)) begin
            state_d = ST_WAIT_ALIGN;
            tmr_clr = 1'b1;
          end else begin
            timeout = tmr_done;
          end
        end
        ST_WAIT_ALIGN: begin
          if (align_status) begin
            state_d = ST_CLR_FAULT;
            tmr_clr = 1'b1;
          end else begin
            timeout = tmr_done;
          end
        end
        ST_CLR_FAULT: begin
          if (clr_pulse_done && status_ok) begin
            state_d = ST_UP;
            tmr_clr = 1'b1;
          end else begin
            timeout = tmr_done;
          end
        end
        ST_UP: begin
          if (link_lost) begin
            state_d         = ST_RST;
            retry_cnt_d     = '0;
            link_drop_cnt_d = sat_inc16(link_drop_cnt_q);
            tmr_clr         = 1'b1;
          end
        end
        default: ;
      endcase
      if (timeout) begin
        retry_cnt_d = retry_inc[2:0];
        state_d     = (retry_inc >= 4'(MAX_RETRY)) ? ST_FAILED : ST_RST;
        tmr_clr     = 1'b1;
      end
    end
  end

  assign cfg_d = {cfg_powerdown, cfg_loopback};

  // controller registers
  always_ff @(posedge usrclk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      retry_cnt_q     <= '0;
      link_drop_cnt_q <= '0;
      cfg_q           <= '0;
    end else begin
      state_q         <= state_d;
      retry_cnt_q     <= retry_cnt_d;
      link_drop_cnt_q <= link_drop_cnt_d;
      cfg_q           <= cfg_d;
    end
  end

  xaui_ctrl_timer #(.W(TMR_W)) u_timer (
    .clk   (usrclk),
    .rst   (reset),
    .clr   (tmr_clr),
    .limit (tmr_limit),
    .done  (tmr_done),
    .count (tmr_count)
  );

  // configuration vector assembly
  always_comb begin
    configuration_vector                = '0;
    configuration_vector[CV_LOOPBACK]   = cfg_q[0];
    configuration_vector[CV_POWERDOWN]  = cfg_q[1];
    configuration_vector[CV_RST_LFAULT] = clr_pulse;
    configuration_vector[CV_RST_RXLINK] = clr_pulse;
  end

  assign core_reset    = (state_q == ST_IDLE) || (state_q == ST_RST);
  assign link_up       = (state_q == ST_UP);
  assign link_failed   = (state_q == ST_FAILED);
  assign state         = state_q;
  assign retry_cnt     = retry_cnt_q;
  assign link_drop_cnt = link_drop_cnt_q;

endmodule

// File: tb/tb_xaui_link_ctrl.sv
// Directed bench for xaui_link_ctrl. Stimulus queues the expected sequence
// of state entries (with outputs and the duration of the state just left);
// a monitor pops and compares one entry on every observed state change.
module tb_xaui_link_ctrl;
  import xaui_ctrl_pkg::*;

  localparam int RST_N    = 32;
  localparam int LOCK_TO  = 64;
  localparam int ALIGN_TO = 40;
  localparam int MAX_R    = 7;

  logic        usrclk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        restart = 1'b0;
  logic        cfg_loopback = 1'b0;
  logic        cfg_powerdown = 1'b0;
  logic [3:0]  mgt_rxlock = 4'h0;
  logic [3:0]  signal_detect = 4'h0;
  logic [3:0]  sync_status = 4'h0;
  logic        align_status = 1'b0;
  logic [7:0]  status_vector = 8'h80;
  logic        core_reset;
  logic [6:0]  configuration_vector;
  logic        link_up;
  logic        link_failed;
  logic [2:0]  state;
  logic [2:0]  retry_cnt;
  logic [15:0] link_drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [2:0]  st;
    logic        crst;
    logic        up;
    logic        failed;
    logic [2:0]  retry;
    logic [15:0] drops;
    logic [15:0] dur;
  } exp_t;

  exp_t exp_q[$];

  xaui_link_ctrl #(
    .RST_CYCLES    (RST_N),
    .LOCK_TIMEOUT  (LOCK_TO),
    .ALIGN_TIMEOUT (ALIGN_TO),
    .MAX_RETRY     (MAX_R)
  ) dut (
    .usrclk               (usrclk),
    .reset                (reset),
    .enable               (enable),
    .restart              (restart),
    .cfg_loopback         (cfg_loopback),
    .cfg_powerdown        (cfg_powerdown),
    .mgt_rxlock           (mgt_rxlock),
    .signal_detect        (signal_detect),
    .sync_status          (sync_status),
    .align_status         (align_status),
    .status_vector        (status_vector),
    .core_reset           (core_reset),
    .configuration_vector (configuration_vector),
    .link_up              (link_up),
    .link_failed          (link_failed),
    .state                (state),
    .retry_cnt            (retry_cnt),
    .link_drop_cnt        (link_drop_cnt)
  );

  always #5 usrclk = ~usrclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic exp_t mk(input logic [2:0] st, input logic [2:0] r,
                              input logic [15:0] d, input logic [15:0] dur);
    exp_t e;
    e.st     = st;
    e.crst   = (st == ST_IDLE) || (st == ST_RST);
    e.up     = (st == ST_UP);
    e.failed = (st == ST_FAILED);
    e.retry  = r;
    e.drops  = d;
    e.dur    = dur;
    return e;
  endfunction

  task automatic push(input logic [2:0] st, input logic [2:0] r,
                      input logic [15:0] d, input int dur);
    exp_q.push_back(mk(st, r, d, 16'(dur)));
  endtask

  // fast bring-up from RST with all status inputs already good
  task automatic push_bringup(input logic [15:0] d);
    push(ST_WAIT_LOCK,  3'd0, d, RST_N);
    push(ST_WAIT_SYNC,  3'd0, d, 1);
    push(ST_WAIT_ALIGN, 3'd0, d, 1);
    push(ST_CLR_FAULT,  3'd0, d, 1);
    push(ST_UP,         3'd0, d, 2);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string name);
    int n;
    n = 0;
    @(negedge usrclk); n++;
    while (state !== s && n < budget) begin
      @(negedge usrclk); n++;
    end
    n_checks++;
    if (state === s) n_pass++;
    else $display("FAIL %s: state %0d expected %0d after %0d cycles", name, state, s, n);
  endtask

  task automatic drop_align;
    align_status = 1'b0;
    @(negedge usrclk);
    align_status = 1'b1;
  endtask

  // monitor: compare each state entry against the queued expectation
  initial begin : monitor
    logic [2:0]  prev;
    int          dur;
    exp_t        e;
    logic [24:0] obs;
    logic [24:0] want;
    @(negedge reset);
    prev = ST_IDLE;
    dur  = 0;
    forever begin
      @(negedge usrclk);
      if (state !== prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_transition: state %0d -> %0d with nothing queued", prev, state);
        end else begin
          e    = exp_q.pop_front();
          obs  = {state, core_reset, link_up, link_failed, retry_cnt, link_drop_cnt};
          want = {e.st, e.crst, e.up, e.failed, e.retry, e.drops};
          check($sformatf("entry_st%0d_from_st%0d", e.st, prev), 32'(obs), 32'(want));
          if (e.dur != 16'd0)
            check($sformatf("cycles_in_st%0d", prev), 32'(dur), 32'(e.dur));
        end
        prev = state;
        dur  = 1;
      end else begin
        dur++;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #1 reset = 1'b1;
    repeat (3) @(negedge usrclk);
    check("rst_state",      32'(state), 32'(ST_IDLE));
    check("rst_core_reset", 32'(core_reset), 32'd1);
    check("rst_cfg",        32'(configuration_vector), 32'd0);
    check("rst_link_up",    32'(link_up), 32'd0);
    check("rst_failed",     32'(link_failed), 32'd0);
    check("rst_retry",      32'(retry_cnt), 32'd0);
    check("rst_drops",      32'(link_drop_cnt), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge usrclk);

    // configuration pass-through is registered
    cfg_loopback  = 1'b1;
    cfg_powerdown = 1'b1;
    #1 check("cfg_before_edge", 32'(configuration_vector[1:0]), 32'd0);
    @(negedge usrclk);
    check("cfg_after_edge", 32'(configuration_vector[1:0]), 32'd3);
    cfg_powerdown = 1'b0;
    @(negedge usrclk);
    check("cfg_pd_clear", 32'(configuration_vector[1:0]), 32'd1);

    // nominal bring-up: lock at 10, sync +5, align +5
    push(ST_RST,        3'd0, 16'd0, 0);
    push(ST_WAIT_LOCK,  3'd0, 16'd0, RST_N);
    push(ST_WAIT_SYNC,  3'd0, 16'd0, 10);
    push(ST_WAIT_ALIGN, 3'd0, 16'd0, 5);
    push(ST_CLR_FAULT,  3'd0, 16'd0, 5);
    push(ST_UP,         3'd0, 16'd0, 2);
    enable = 1'b1;
    wait_state(ST_WAIT_LOCK, 100, "s1_wait_lock");
    repeat (9) @(negedge usrclk);
    mgt_rxlock = 4'hF;
    wait_state(ST_WAIT_SYNC, 5, "s1_wait_sync");
    repeat (4) @(negedge usrclk);
    sync_status   = 4'hF;
    signal_detect = 4'hF;
    wait_state(ST_WAIT_ALIGN, 5, "s1_wait_align");
    repeat (4) @(negedge usrclk);
    align_status = 1'b1;
    wait_state(ST_CLR_FAULT, 5, "s1_clr_fault");
    check("clr_bits_cycle1", 32'(configuration_vector[3:2]), 32'd3);
    @(negedge usrclk);
    check("clr_bits_cycle2", 32'(configuration_vector[3:2]), 32'd3);
    @(negedge usrclk);
    check("clr_bits_in_up", 32'(configuration_vector[3:2]), 32'd0);
    check("s1_link_up",     32'(link_up), 32'd1);

    // one-cycle alignment loss in UP
    push(ST_RST, 3'd0, 16'd1, 0);
    push_bringup(16'd1);
    drop_align();
    wait_state(ST_UP, 100, "s2_up");

    // alignment arrives on the timeout cycle: success wins
    push(ST_RST,        3'd0, 16'd1, 0);
    push(ST_WAIT_LOCK,  3'd0, 16'd1, RST_N);
    push(ST_WAIT_SYNC,  3'd0, 16'd1, 1);
    push(ST_WAIT_ALIGN, 3'd0, 16'd1, 1);
    push(ST_CLR_FAULT,  3'd0, 16'd1, ALIGN_TO);
    push(ST_UP,         3'd0, 16'd1, 2);
    restart = 1'b1;
    @(negedge usrclk);
    restart      = 1'b0;
    align_status = 1'b0;
    wait_state(ST_WAIT_ALIGN, 100, "s3_wait_align");
    repeat (ALIGN_TO - 1) @(negedge usrclk);
    align_status = 1'b1;
    wait_state(ST_UP, 10, "s3_up");

    // lock never completes: seven attempts then FAILED
    push(ST_RST, 3'd0, 16'd1, 0);
    for (int i = 1; i <= MAX_R; i++) begin
      push(ST_WAIT_LOCK, 3'(i - 1), 16'd1, RST_N);
      if (i < MAX_R) push(ST_RST, 3'(i), 16'd1, LOCK_TO);
      else           push(ST_FAILED, 3'(i), 16'd1, LOCK_TO);
    end
    restart = 1'b1;
    @(negedge usrclk);
    restart    = 1'b0;
    mgt_rxlock = 4'h7;
    wait_state(ST_FAILED, 1000, "s4_failed");
    repeat (5) @(negedge usrclk);
    check("s4_failed_hold", 32'(link_failed), 32'd1);
    check("s4_retry",       32'(retry_cnt), 32'd7);

    // restart out of FAILED
    push(ST_RST, 3'd0, 16'd1, 0);
    push_bringup(16'd1);
    restart    = 1'b1;
    mgt_rxlock = 4'hF;
    @(negedge usrclk);
    restart = 1'b0;
    wait_state(ST_UP, 100, "s5_up");

    // drop counter saturation
    force dut.link_drop_cnt_q = 16'hFFFE;
    @(negedge usrclk);
    release dut.link_drop_cnt_q;
    push(ST_RST, 3'd0, 16'hFFFF, 0);
    push_bringup(16'hFFFF);
    drop_align();
    wait_state(ST_UP, 100, "s6_up");
    push(ST_RST,       3'd0, 16'hFFFF, 0);
    push(ST_WAIT_LOCK, 3'd0, 16'hFFFF, RST_N);
    push(ST_WAIT_SYNC, 3'd0, 16'hFFFF, 1);
    drop_align();
    sync_status = 4'h0;
    wait_state(ST_WAIT_SYNC, 100, "s6_wait_sync");
    check("s6_drops_sat", 32'(link_drop_cnt), 32'hFFFF);

    // asynchronous reset mid WAIT_SYNC
    repeat (3) @(negedge usrclk);
    push(ST_IDLE, 3'd0, 16'd0, 0);
    #2 reset = 1'b1;
    #1;
    check("arst_state",      32'(state), 32'(ST_IDLE));
    check("arst_core_reset", 32'(core_reset), 32'd1);
    check("arst_cfg",        32'(configuration_vector), 32'd0);
    check("arst_link_up",    32'(link_up), 32'd0);
    check("arst_failed",     32'(link_failed), 32'd0);
    check("arst_retry",      32'(retry_cnt), 32'd0);
    check("arst_drops",      32'(link_drop_cnt), 32'd0);
    @(negedge usrclk);
    mgt_rxlock  = 4'h0;
    sync_status = 4'hF;
    push(ST_RST,       3'd0, 16'd0, 0);
    push(ST_WAIT_LOCK, 3'd0, 16'd0, RST_N);
    push(ST_IDLE,      3'd0, 16'd0, 0);
    @(negedge usrclk);
    reset = 1'b0;

    // enable low together with restart: IDLE wins
    wait_state(ST_WAIT_LOCK, 100, "s8_wait_lock");
    repeat (3) @(negedge usrclk);
    enable  = 1'b0;
    restart = 1'b1;
    @(negedge usrclk);
    restart = 1'b0;
    check("s8_state_idle", 32'(state), 32'(ST_IDLE));

    repeat (3) @(negedge usrclk);
    check("expect_queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
